// File: rtl/sos_cascade_sequencer.sv
// Sequencer and coefficient manager for a cascade of second-order IIR sections.
// One sample is accepted per handshake and held on the cascade input for a settle
// time. A single-cycle enable then advances every section's delay line once, and
// the cascade response is returned on an output handshake. Coefficients are
// staged in a shadow bank and copied to the active bank only while idle.
module sos_cascade_sequencer #(
  parameter int IIR_WD     = 32,
  parameter int COF_WD     = 32,
  parameter int NUM_SOS    = 4,
  parameter int COEF_FRAC  = 20,
  parameter int SETTLE_CYC = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [IIR_WD-1:0]             s_sample_i,
  output logic [IIR_WD-1:0]             casc_sample_o,
  input  logic [IIR_WD-1:0]             casc_resp_i,
  output logic                          sos_en_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [IIR_WD-1:0]             m_resp_o,
  input  logic                          cfg_we_i,
  input  logic [3:0]                    cfg_sec_i,
  input  logic [2:0]                    cfg_idx_i,
  input  logic [COF_WD-1:0]             cfg_data_i,
  input  logic                          cfg_commit_i,
  output logic                          cfg_pending_o,
  output logic [NUM_SOS*5*COF_WD-1:0]   coeff_o
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    FIRE   = 2'd2,
    OUT    = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   settle_cnt_reg;
  logic [IIR_WD-1:0]  casc_sample_reg;
  logic [IIR_WD-1:0]  m_resp_reg;
  logic               pending_reg;
  logic               accept;
  logic               copy_en;

  assign casc_sample_o = casc_sample_reg;
  assign m_resp_o      = m_resp_reg;
  assign cfg_pending_o = pending_reg;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake/enable decode; a pending commit blocks acceptance
  always_comb begin
    state_next = state_reg;
    s_ready_o  = 1'b0;
    sos_en_o   = 1'b0;
    m_valid_o  = 1'b0;
    accept     = 1'b0;
    copy_en    = 1'b0;
    case (state_reg)
      IDLE: begin
        s_ready_o = !pending_reg;
        if (pending_reg) begin
          copy_en = 1'b1;
        end else if (s_valid_i) begin
          accept     = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_reg == '0) begin
          state_next = FIRE;
        end
      end
      FIRE: begin
        sos_en_o   = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        m_valid_o = 1'b1;
        if (m_ready_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Settle counter: loaded on accept, counts down while settling
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      settle_cnt_reg <= '0;
    end else if (accept) begin
      settle_cnt_reg <= CNT_W'(SETTLE_CYC - 1);
    end else if (state_reg == SETTLE && settle_cnt_reg != '0) begin
      settle_cnt_reg <= settle_cnt_reg - 1'b1;
    end
  end

  // Cascade input is only updated on the accepting edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      casc_sample_reg <= '0;
    end else if (accept) begin
      casc_sample_reg <= s_sample_i;
    end
  end

  // Capture the cascade response as the delay lines advance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_resp_reg <= '0;
    end else if (state_reg == FIRE) begin
      m_resp_reg <= casc_resp_i;
    end
  end

  // Commit request: a request arriving on the copy cycle stays pending
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_reg <= 1'b0;
    end else if (copy_en) begin
      pending_reg <= cfg_commit_i;
    end else begin
      pending_reg <= pending_reg | cfg_commit_i;
    end
  end

  // One shadow/active register pair per coefficient slot
  generate
    for (genvar gi = 0; gi < NUM_SOS * 5; gi++) begin : g_coef
      localparam int SEC = gi / 5;
      localparam int IDX = gi % 5;
      localparam logic [COF_WD-1:0] RST_VAL =
        (IDX == 0) ? (COF_WD'(1) << COEF_FRAC) : '0;

      logic [COF_WD-1:0] shadow_reg;
      logic [COF_WD-1:0] active_reg;
      logic              wr_hit;

      // Out-of-range section/index values never match any slot
      assign wr_hit = cfg_we_i && (cfg_sec_i == 4'(SEC)) && (cfg_idx_i == 3'(IDX));

      // Shadow slot written in any state
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          shadow_reg <= RST_VAL;
        end else if (wr_hit) begin
          shadow_reg <= cfg_data_i;
        end
      end

      // Active slot takes the pre-write shadow value on the copy cycle
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          active_reg <= RST_VAL;
        end else if (copy_en) begin
          active_reg <= shadow_reg;
        end
      end

      assign coeff_o[gi*COF_WD +: COF_WD] = active_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sos_cascade_sequencer.sv
// Bench for sos_cascade_sequencer: a behavioural DF-II cascade drives casc_resp_i,
// a reference model predicts responses into a scoreboard queue, and a monitor
// pops and compares whenever the DUT presents a response.
module tb_sos_cascade_sequencer;

  localparam int NS = 4;
  localparam int CW = 32;
  localparam int DW = 32;
  localparam int FR = 20;
  localparam int SC = 2;

  typedef logic [NS*5*CW-1:0] cbank_t;
  typedef logic [NS*2*DW-1:0] st_t;

  logic            clk, rst_n;
  logic            s_valid, s_ready;
  logic [DW-1:0]   s_sample, casc_sample, casc_resp, m_resp;
  logic            sos_en, m_valid, m_ready;
  logic            cfg_we, cfg_commit, cfg_pending;
  logic [3:0]      cfg_sec;
  logic [2:0]      cfg_idx;
  logic [CW-1:0]   cfg_data;
  cbank_t          coeff;

  logic            rand_mode, rnd_bit, m_ready_man;
  assign m_ready = rand_mode ? rnd_bit : m_ready_man;

  sos_cascade_sequencer #(
    .IIR_WD(DW), .COF_WD(CW), .NUM_SOS(NS), .COEF_FRAC(FR), .SETTLE_CYC(SC)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_sample_i(s_sample),
    .casc_sample_o(casc_sample), .casc_resp_i(casc_resp), .sos_en_o(sos_en),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_resp_o(m_resp),
    .cfg_we_i(cfg_we), .cfg_sec_i(cfg_sec), .cfg_idx_i(cfg_idx),
    .cfg_data_i(cfg_data), .cfg_commit_i(cfg_commit),
    .cfg_pending_o(cfg_pending), .coeff_o(coeff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rnd_bit = 1'b1;
    forever begin
      @(posedge clk); #1;
      rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- behavioural cascade arithmetic ----------------
  function automatic cbank_t reset_bank();
    cbank_t b;
    b = '0;
    for (int s = 0; s < NS; s++) b[(s*5)*CW +: CW] = 32'(1) << FR;
    return b;
  endfunction

  // Returns {next delay state, output} for one sample through all sections
  function automatic logic [NS*2*DW+DW-1:0] casc_eval(input logic [DW-1:0] x,
                                                      input cbank_t c, input st_t st);
    logic signed [DW-1:0] v, w, w1, w2, b0, b1, b2, a1, a2;
    longint acc;
    st_t stn;
    v = x;
    stn = st;
    for (int s = 0; s < NS; s++) begin
      b0 = c[(s*5+0)*CW +: CW];
      b1 = c[(s*5+1)*CW +: CW];
      b2 = c[(s*5+2)*CW +: CW];
      a1 = c[(s*5+3)*CW +: CW];
      a2 = c[(s*5+4)*CW +: CW];
      w1 = st[(2*s)*DW +: DW];
      w2 = st[(2*s+1)*DW +: DW];
      acc = longint'(a1) * longint'(w1) + longint'(a2) * longint'(w2);
      w = v - DW'(acc >>> FR);
      acc = longint'(b0) * longint'(w) + longint'(b1) * longint'(w1) + longint'(b2) * longint'(w2);
      v = DW'(acc >>> FR);
      stn[(2*s)*DW +: DW]   = w;
      stn[(2*s+1)*DW +: DW] = w1;
    end
    return {stn, v};
  endfunction

  // Environment cascade: combinational response, delay lines advance on enable
  st_t env_st;
  logic [NS*2*DW+DW-1:0] env_pack;
  assign env_pack  = casc_eval(casc_sample, coeff, env_st);
  assign casc_resp = env_pack[DW-1:0];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) env_st <= '0;
    else if (sos_en) env_st <= env_pack[NS*2*DW+DW-1:DW];
  end

  // ---------------- reference model and scoreboard ----------------
  cbank_t model_act, model_shadow;
  st_t    model_st;
  logic [DW-1:0] exp_q[$];
  int total, bad, en_count, accepted_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_bank(input string nm, input cbank_t exp);
    total++;
    if (coeff !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, coeff, exp);
    end
  endtask

  function automatic void model_write(input int s, input int k, input logic [CW-1:0] d);
    if (s < NS && k <= 4) model_shadow[(s*5+k)*CW +: CW] = d;
  endfunction

  function automatic void model_reset();
    model_act    = reset_bank();
    model_shadow = reset_bank();
    model_st     = '0;
  endfunction

  always @(negedge clk) if (rst_n && sos_en) en_count++;

  // Monitor: response must match the queue head for as long as it is presented
  always @(negedge clk) begin
    if (rst_n && m_valid) begin
      chk("resp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        chk("resp", 64'(m_resp), 64'(exp_q[0]));
        if (m_ready) begin
          $display("resp %08h ok=%0d", m_resp, m_resp === exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cfg_cycle(input bit we, input int s, input int k,
                           input logic [CW-1:0] d, input bit commit);
    cfg_we = we; cfg_sec = 4'(s); cfg_idx = 3'(k); cfg_data = d; cfg_commit = commit;
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic cfg_write(input int s, input int k, input logic [CW-1:0] d);
    model_write(s, k, d);
    cfg_cycle(1'b1, s, k, d, 1'b0);
  endtask

  task automatic commit_and_wait();
    bit done;
    done = 1'b0;
    cfg_cycle(1'b0, 0, 0, '0, 1'b1);
    for (int i = 0; i < 80; i++) begin
      if (!cfg_pending) begin done = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("commit_done", 64'(done), 64'd1);
    model_act = model_shadow;
    chk_bank("coeff_commit", model_act);
  endtask

  task automatic accept_sample(input logic [DW-1:0] x, input bit expect_resp);
    logic [NS*2*DW+DW-1:0] p;
    bit ok;
    ok = 1'b0;
    s_sample = x; s_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1'b1; break; end
    end
    chk("accept", 64'(ok), 64'd1);
    if (ok && expect_resp) begin
      p = casc_eval(x, model_act, model_st);
      model_st = p[NS*2*DW+DW-1:DW];
      exp_q.push_back(p[DW-1:0]);
      accepted_cnt++;
      $display("send %08h expect %08h", x, p[DW-1:0]);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle_out();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !m_valid) begin done = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("drain", 64'(done), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_s_ready"}, 64'(s_ready), 64'd1);
    chk({nm, "_m_valid"}, 64'(m_valid), 64'd0);
    chk({nm, "_sos_en"}, 64'(sos_en), 64'd0);
    chk({nm, "_casc_sample"}, 64'(casc_sample), 64'd0);
    chk({nm, "_m_resp"}, 64'(m_resp), 64'd0);
    chk({nm, "_pending"}, 64'(cfg_pending), 64'd0);
    chk_bank({nm, "_coeff"}, reset_bank());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, en_before;
    logic [DW-1:0] x;
    cbank_t pre;
    total = 0; bad = 0; en_count = 0; accepted_cnt = 0;
    rand_mode = 1'b0; m_ready_man = 1'b1;
    s_valid = 1'b0; s_sample = '0;
    cfg_we = 1'b0; cfg_commit = 1'b0; cfg_sec = '0; cfg_idx = '0; cfg_data = '0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk_reset_outputs("reset");

    // Out-of-range writes are ignored
    cfg_write(NS, 5, 32'hFFFF_FFFF);
    cfg_write(NS, 0, 32'hFFFF_FFFF);
    cfg_write(0, 5, 32'hFFFF_FFFF);
    commit_and_wait();
    chk_bank("coeff_invalid_write", reset_bank());

    // Pass-through sample, latency and single enable pulse
    en_before = en_count;
    accept_sample(32'h0000_1234, 1'b1);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1; lat++;
      if (m_valid) break;
    end
    chk("latency", 64'(lat), 64'(SC + 1));
    wait_idle_out();
    chk("en_pulse_single", 64'(en_count - en_before), 64'd1);

    // Half-gain commit: pending visible one IDLE cycle with ready low
    cfg_write(0, 0, 32'h0008_0000);
    cfg_cycle(1'b0, 0, 0, '0, 1'b1);
    chk("pending_set", 64'(cfg_pending), 64'd1);
    chk("ready_low_copy", 64'(s_ready), 64'd0);
    chk_bank("coeff_before_copy", model_act);
    @(posedge clk); #1;
    chk("pending_clr", 64'(cfg_pending), 64'd0);
    chk("ready_after_copy", 64'(s_ready), 64'd1);
    model_act = model_shadow;
    chk_bank("coeff_after_copy", model_act);
    accept_sample(32'h0000_2000, 1'b1);
    wait_idle_out();

    // Write and commit on the copy cycle: copy takes old shadow, pending stays set
    cfg_write(1, 1, 32'h0001_1111);
    cfg_cycle(1'b0, 0, 0, '0, 1'b1);
    pre = model_shadow;
    cfg_cycle(1'b1, 1, 1, 32'h0002_2222, 1'b1);
    model_write(1, 1, 32'h0002_2222);
    model_act = pre;
    chk("pending_recommit", 64'(cfg_pending), 64'd1);
    chk_bank("coeff_prewrite", model_act);
    @(posedge clk); #1;
    chk("pending_clr2", 64'(cfg_pending), 64'd0);
    model_act = model_shadow;
    chk_bank("coeff_postwrite", model_act);

    // Back-pressure in OUT
    m_ready_man = 1'b0;
    accept_sample(32'h0000_0777, 1'b1);
    for (int i = 0; i < 20 && !m_valid; i++) begin @(posedge clk); #1; end
    en_before = en_count;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(m_valid), 64'd1);
      chk("hold_ready", 64'(s_ready), 64'd0);
    end
    chk("hold_no_en", 64'(en_count), 64'(en_before));
    m_ready_man = 1'b1;
    @(posedge clk); #1;
    chk("release_idle", 64'(m_valid), 64'd0);

    // Commit during SETTLE: active bank frozen until back in IDLE
    cfg_write(1, 0, 32'h0004_0000);
    accept_sample(32'h0000_4000, 1'b1);
    cfg_cycle(1'b0, 0, 0, '0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (!cfg_pending) break;
      chk_bank("coeff_frozen", model_act);
      @(posedge clk); #1;
    end
    chk("settle_commit_done", 64'(cfg_pending), 64'd0);
    model_act = model_shadow;
    chk_bank("coeff_settle_commit", model_act);
    wait_idle_out();

    // Reset while settling: immediate reset outputs, no enable for the lost sample
    accept_sample(32'h0000_5555, 1'b0);
    en_before = en_count;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_en", 64'(en_count), 64'(en_before));
    en_before = en_count;
    accept_sample(32'h0000_0abc, 1'b1);
    wait_idle_out();
    chk("after_abort_en", 64'(en_count - en_before), 64'd1);

    // Randomised traffic with coefficient updates and random back-pressure
    rand_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      x = DW'(int'($urandom_range(0, 65535)) - 32768);
      accept_sample(x, 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        for (int j = 0; j < 3; j++) begin
          int s, k;
          logic [CW-1:0] d;
          s = int'($urandom_range(0, NS + 1));
          k = int'($urandom_range(0, 7));
          if (k < 3) d = CW'(int'($urandom_range(0, 2**21)) - 2**20);
          else       d = CW'(int'($urandom_range(0, 2**19)) - 2**18);
          cfg_write(s, k, d);
        end
        commit_and_wait();
      end
    end
    rand_mode = 1'b0;
    m_ready_man = 1'b1;
    wait_idle_out();

    chk("en_total", 64'(en_count), 64'(accepted_cnt));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sos_cascade_sequencer.md
Name: sos_cascade_sequencer

Overview:
Sequencer and coefficient manager for a cascade of NUM_SOS direct-form-II second-order IIR sections. It accepts one input sample per valid/ready handshake and presents it to the cascade. It waits a fixed settle time for the combinational cascade path, then pulses the shared section enable so every section's delay line advances exactly once. It also captures the cascade response and returns it on an output handshake. Coefficients are written into a shadow bank and committed atomically to the active bank, only between samples.

Parameters:
IIR_WD, 32, sample/response width (two's complement)
COF_WD, 32, coefficient width (two's complement, COEF_FRAC fractional bits)
NUM_SOS, 4, number of cascaded sections (1..16)
COEF_FRAC, 20, fractional bits of coefficients (1.0 = 1<<COEF_FRAC)
SETTLE_CYC, 2, cycles the cascade input is held before the enable pulse (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
s_valid_i  in  1  input sample valid
s_ready_o  out  1  input sample ready
s_sample_i  in  IIR_WD  input sample
casc_sample_o  out  IIR_WD  registered sample driven to first section
casc_resp_i  in  IIR_WD  combinational response from last section
sos_en_o  out  1  enable to all sections' delay registers
m_valid_o  out  1  response valid
m_ready_i  in  1  response ready
m_resp_o  out  IIR_WD  registered response
cfg_we_i  in  1  shadow coefficient write strobe
cfg_sec_i  in  4  section index
cfg_idx_i  in  3  coefficient index: 0=b0 1=b1 2=b2 3=a1 4=a2
cfg_data_i  in  COF_WD  coefficient value
cfg_commit_i  in  1  request shadow->active copy (pulse)
cfg_pending_o  out  1  commit requested, not yet applied
coeff_o  out  NUM_SOS*5*COF_WD  active bank; section s, index k at bits [(s*5+k)*COF_WD +: COF_WD]

Behaviour:
- Reset (async): FSM=IDLE; s_ready_o=1; m_valid_o=0; sos_en_o=0; casc_sample_o=0; m_resp_o=0; cfg_pending_o=0.
- Reset coefficients, shadow and active: b0=1<<COEF_FRAC, all others 0. Every section is a pass-through.
- FSM states: IDLE, SETTLE, FIRE, OUT.
- IDLE:
  - s_ready_o = !cfg_pending_o.
  - If cfg_pending_o: copy shadow->active, clear pending, accept nothing this cycle.
  - Else on s_valid_i: latch s_sample_i into casc_sample_o, load settle counter with SETTLE_CYC-1, go to SETTLE.
- SETTLE: s_ready_o=0. At counter==0 go to FIRE; otherwise decrement.
- FIRE: sos_en_o=1 for exactly this cycle. At its end, m_resp_o<=casc_resp_i and the state goes to OUT.
- OUT: m_valid_o=1 and m_resp_o held stable. On m_ready_i, go to IDLE (m_valid_o low next cycle).
- sos_en_o is high only in FIRE; exactly one pulse per accepted sample.
- Latency: m_valid_o first high SETTLE_CYC+1 edges after the accepting edge. Minimum sample period is SETTLE_CYC+3 cycles when m_ready_i is held high.
- casc_sample_o changes only on the accept edge.
- Shadow writes:
  - cfg_we_i writes shadow[cfg_sec_i][cfg_idx_i] in any state.
  - Writes with cfg_sec_i>=NUM_SOS or cfg_idx_i>4 are ignored.
- Commit:
  - cfg_commit_i sets pending in any state. A commit while already pending is absorbed.
  - The copy happens only in IDLE, so the active bank never changes between accept and FIRE.
  - Write and commit-copy in the same cycle: the copy takes the pre-write shadow; the write lands in shadow only.
  - cfg_commit_i in the same cycle as the copy leaves pending set.
- The a1/a2 sign convention is the section's concern; this block stores values verbatim.
- Reset mid-operation: the FSM returns to IDLE immediately, any in-flight sample is discarded, no sos_en_o pulse is produced, and coefficients revert to the reset values.

Test Plan:
- Reset, SETTLE_CYC=2, m_ready_i=1, send 0x0000_1234 → m_resp_o=0x0000_1234. m_valid_o rises 3 edges after the accept. Exactly one sos_en_o pulse.
- Write sec0 b0=0x0008_0000 (0.5), commit, then send 0x0000_2000 → m_resp_o=0x0000_1000. cfg_pending_o drops after the first IDLE cycle. s_ready_o is low during that cycle.
- Hold m_ready_i=0 for 10 cycles in OUT → m_valid_o stays high, m_resp_o is stable, s_ready_o=0, no extra sos_en_o. Release → IDLE the next cycle.
- Pulse cfg_commit_i while in SETTLE → coeff_o unchanged until the FSM returns to IDLE. The copy happens before the next sample is accepted.
- Write cfg_sec_i=NUM_SOS and cfg_idx_i=5 with data 0xFFFF_FFFF, then commit → coeff_o equals its reset values.
- Assert rst_ni low in SETTLE → outputs at their reset values asynchronously. No sos_en_o pulse for the aborted sample. The next sample completes normally.
